// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the synchronous-read icache and
// registers the fetched instruction. Optional FETCH_PERF_EN adds fetch/bubble counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] alu_out,
  input  logic [31:0] icache_dout,
  output logic [31:0] icache_addr,
  output logic        icache_re,
  output logic [31:0] pc_out,
  output logic [31:0] prev_inst,
  output logic [31:0] prev_pc,
  output logic        inst_valid,
  output logic        fetch_misaligned
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e      state_q, state_d, state_s;
  logic [31:0] pc_q, pc_d;
  logic [31:0] prev_inst_q, prev_inst_d;
  logic [31:0] prev_pc_q, prev_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] next_pc_s;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
`endif

  // The register only remembers "reset seen" or "running"; the first cycle with rst
  // high after reset is the BOOT cycle, so BOOT needs no registered encoding of its own.
  always_comb begin
    state_s = ST_RST;
    if (!rst) begin
      state_s = ST_RST;
    end else if (state_q == ST_RUN) begin
      state_s = ST_RUN;
    end else begin
      state_s = ST_BOOT;
    end
  end

  always_comb begin
    state_d      = state_q;
    next_pc_s    = pc_q;
    icache_re    = 1'b0;
    icache_addr  = RESET_PC;
    pc_d         = pc_q;
    prev_inst_d  = prev_inst_q;
    prev_pc_d    = prev_pc_q;
    inst_valid_d = inst_valid_q;
    misaligned_d = 1'b0;
`ifdef FETCH_PERF_EN
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
`endif
    case (state_s)
      ST_RST: begin
        state_d = ST_RST;
      end
      ST_BOOT: begin
        state_d      = ST_RUN;
        icache_re    = 1'b1;
        icache_addr  = RESET_PC;
        pc_d         = RESET_PC;
        prev_inst_d  = NOP;
        inst_valid_d = 1'b0;
      end
      ST_RUN: begin
        state_d   = ST_RUN;
        icache_re = 1'b1;
        case (pc_sel)
          2'b00: begin
            // Refetch: the instruction on icache_dout will arrive again next cycle.
            next_pc_s    = pc_q;
            prev_inst_d  = NOP;
            inst_valid_d = 1'b0;
          end
          2'b01: begin
            next_pc_s    = {alu_out[31:2], 2'b00};
            prev_inst_d  = NOP;
            inst_valid_d = 1'b0;
            misaligned_d = alu_out[1];
          end
          default: begin
            next_pc_s    = pc_q + 32'd4;
            prev_inst_d  = icache_dout;
            prev_pc_d    = pc_q;
            inst_valid_d = 1'b1;
          end
        endcase
        icache_addr = next_pc_s;
        pc_d        = next_pc_s;
`ifdef FETCH_PERF_EN
        if (inst_valid_d) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
          bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
`endif
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_PC;
      prev_inst_q  <= NOP;
      prev_pc_q    <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
`ifdef FETCH_PERF_EN
      fetch_cnt_q  <= 32'h0000_0000;
      bubble_cnt_q <= 32'h0000_0000;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      prev_inst_q  <= prev_inst_d;
      prev_pc_q    <= prev_pc_d;
      inst_valid_q <= inst_valid_d;
      misaligned_q <= misaligned_d;
`ifdef FETCH_PERF_EN
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
`endif
    end
  end

  assign pc_out           = pc_q;
  assign prev_inst        = prev_inst_q;
  assign prev_pc          = prev_pc_q;
  assign inst_valid       = inst_valid_q;
  assign fetch_misaligned = misaligned_q;
`ifdef FETCH_PERF_EN
  assign fetch_count      = fetch_cnt_q;
  assign bubble_count     = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized pc_sel/reset
// traffic checked against a fetch-stream reference model.
module tb_fetch_stage;
  localparam logic [31:0] RPC  = 32'h4000_0000;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [31:0] alu_out, icache_dout, icache_addr, pc_out, prev_inst, prev_pc;
  logic        icache_re, inst_valid, fetch_misaligned;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .alu_out(alu_out), .icache_dout(icache_dout),
    .icache_addr(icache_addr), .icache_re(icache_re), .pc_out(pc_out), .prev_inst(prev_inst),
    .prev_pc(prev_pc), .inst_valid(inst_valid), .fetch_misaligned(fetch_misaligned)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
  );

  int total = 0;
  int bad = 0;

  // Reference model: architectural fetch state
  bit          m_run = 1'b0;
  logic [31:0] m_pc, m_pi, m_pp, m_fc, m_bc;
  logic        m_v, m_mis;
  logic [31:0] exp_addr, obs_addr;
  logic        exp_re, obs_re;

  // Instruction memory contents as a function of address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock: drive inputs, capture the fetch request, advance the model, then
  // return the icache data for the address issued at this edge.
  task automatic step(input logic r, input logic [1:0] s, input logic [31:0] a);
    rst = r; pc_sel = s; alu_out = a;
    #1;
    if (!r) begin
      exp_re = 1'b0; exp_addr = RPC;
    end else if (!m_run) begin
      exp_re = 1'b1; exp_addr = RPC;
    end else begin
      exp_re = 1'b1;
      if (s == 2'b00) exp_addr = m_pc;
      else if (s == 2'b01) exp_addr = a & 32'hFFFF_FFFC;
      else exp_addr = m_pc + 32'd4;
    end
    obs_addr = icache_addr; obs_re = icache_re;
    if (!r) begin
      m_run = 1'b0; m_pc = RPC; m_pi = NOPI; m_pp = 32'd0; m_v = 1'b0; m_mis = 1'b0;
      m_fc = 32'd0; m_bc = 32'd0;
    end else if (!m_run) begin
      m_run = 1'b1; m_pc = RPC; m_pi = NOPI; m_v = 1'b0; m_mis = 1'b0;
    end else begin
      m_mis = (s == 2'b01) && a[1];
      if (s[1]) begin
        m_pi = mem(m_pc); m_pp = m_pc; m_v = 1'b1; m_fc = m_fc + 32'd1;
      end else begin
        m_pi = NOPI; m_v = 1'b0; m_bc = m_bc + 32'd1;
      end
      m_pc = exp_addr;
    end
    @(posedge clk);
    #1;
    icache_dout = exp_re ? mem(exp_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 2'($urandom_range(0, 3)), $urandom);
    if (obs_re !== 1'b0) begin bad++; $display("FAIL rst_re got=%b want=0", obs_re); end total++;
    if (obs_addr !== RPC) begin bad++; $display("FAIL rst_addr got=%h want=%h", obs_addr, RPC); end total++;
    if (pc_out !== RPC) begin bad++; $display("FAIL rst_pc got=%h want=%h", pc_out, RPC); end total++;
    if (prev_inst !== NOPI) begin bad++; $display("FAIL rst_inst got=%h want=%h", prev_inst, NOPI); end total++;
    if (prev_pc !== 32'd0) begin bad++; $display("FAIL rst_prev_pc got=%h want=0", prev_pc); end total++;
    if ({inst_valid, fetch_misaligned} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b want=00", {inst_valid, fetch_misaligned}); end total++;
  endtask

  task automatic test_sequential();
    logic [31:0] want_addr [3] = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b10, $urandom);
      if (obs_addr !== want_addr[i] || obs_re !== 1'b1) begin bad++; $display("FAIL seq_addr%0d got=%h/%b want=%h/1", i, obs_addr, obs_re, want_addr[i]); end total++;
      if (i == 0 && inst_valid !== 1'b0) begin bad++; $display("FAIL seq_boot_valid got=%b want=0", inst_valid); end total++;
      if (i == 1 && (inst_valid !== 1'b1 || prev_pc !== RPC || prev_inst !== mem(RPC))) begin
        bad++; $display("FAIL seq_first got=%b/%h/%h want=1/%h/%h", inst_valid, prev_pc, prev_inst, RPC, mem(RPC));
      end total++;
    end
  endtask

  task automatic test_redirect();
    step(1'b1, 2'b01, 32'h4000_0100);
    if (obs_addr !== 32'h4000_0100) begin bad++; $display("FAIL redir_addr got=%h want=40000100", obs_addr); end total++;
    if (prev_inst !== NOPI || inst_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%h/%b want=%h/0", prev_inst, inst_valid, NOPI); end total++;
    step(1'b1, 2'b10, $urandom);
    if (prev_pc !== 32'h4000_0100 || inst_valid !== 1'b1) begin bad++; $display("FAIL redir_target got=%h/%b want=40000100/1", prev_pc, inst_valid); end total++;
  endtask

  task automatic test_hold();
    step(1'b1, 2'b01, 32'h4000_0010);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00, $urandom);
      if (obs_addr !== 32'h4000_0010) begin bad++; $display("FAIL hold_addr%0d got=%h want=40000010", i, obs_addr); end total++;
      if (prev_inst !== NOPI || inst_valid !== 1'b0) begin bad++; $display("FAIL hold_bubble%0d got=%h/%b want=%h/0", i, prev_inst, inst_valid, NOPI); end total++;
    end
    step(1'b1, 2'b10, $urandom);
    if (prev_pc !== 32'h4000_0010 || prev_inst !== mem(32'h4000_0010)) begin bad++; $display("FAIL hold_release got=%h/%h want=40000010/%h", prev_pc, prev_inst, mem(32'h4000_0010)); end total++;
    step(1'b1, 2'b10, $urandom);
    if (prev_pc !== 32'h4000_0014) begin bad++; $display("FAIL hold_once got=%h want=40000014", prev_pc); end total++;
  endtask

  task automatic test_misaligned();
    step(1'b1, 2'b01, 32'h4000_0206);
    if (obs_addr !== 32'h4000_0204 || fetch_misaligned !== 1'b1) begin bad++; $display("FAIL mis_set got=%h/%b want=40000204/1", obs_addr, fetch_misaligned); end total++;
    step(1'b1, 2'b10, $urandom);
    if (fetch_misaligned !== 1'b0 || prev_pc !== 32'h4000_0204) begin bad++; $display("FAIL mis_pulse got=%b/%h want=0/40000204", fetch_misaligned, prev_pc); end total++;
    step(1'b1, 2'b01, 32'h4000_0205);
    if (obs_addr !== 32'h4000_0204 || fetch_misaligned !== 1'b0) begin bad++; $display("FAIL mis_bit0 got=%h/%b want=40000204/0", obs_addr, fetch_misaligned); end total++;
  endtask

  task automatic test_wrap();
    step(1'b1, 2'b01, 32'hFFFF_FFFC);
    step(1'b1, 2'b11, $urandom);
    if (obs_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_addr got=%h want=00000000", obs_addr); end total++;
    if (pc_out !== 32'h0000_0000 || prev_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_state got=%h/%h want=00000000/fffffffc", pc_out, prev_pc); end total++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 2'b10, $urandom);
    step(1'b0, 2'b01, 32'h4000_0300);
    if (prev_inst !== NOPI || pc_out !== RPC || inst_valid !== 1'b0) begin bad++; $display("FAIL midrst got=%h/%h/%b want=%h/%h/0", prev_inst, pc_out, inst_valid, NOPI, RPC); end total++;
    step(1'b1, 2'b01, 32'h1234_5678);
    if (obs_addr !== RPC || pc_out !== RPC) begin bad++; $display("FAIL boot_ignores_sel got=%h/%h want=%h", obs_addr, pc_out, RPC); end total++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), 2'($urandom_range(0, 3)), $urandom);
      if (obs_addr !== exp_addr || obs_re !== exp_re) begin bad++; $display("FAIL rnd_req%0d got=%h/%b want=%h/%b", i, obs_addr, obs_re, exp_addr, exp_re); end total++;
      if (pc_out !== m_pc) begin bad++; $display("FAIL rnd_pc%0d got=%h want=%h", i, pc_out, m_pc); end total++;
      if (prev_inst !== m_pi || prev_pc !== m_pp) begin bad++; $display("FAIL rnd_prev%0d got=%h/%h want=%h/%h", i, prev_inst, prev_pc, m_pi, m_pp); end total++;
      if (inst_valid !== m_v || fetch_misaligned !== m_mis) begin bad++; $display("FAIL rnd_flags%0d got=%b%b want=%b%b", i, inst_valid, fetch_misaligned, m_v, m_mis); end total++;
`ifdef FETCH_PERF_EN
      if (fetch_count !== m_fc || bubble_count !== m_bc) begin bad++; $display("FAIL rnd_perf%0d got=%0d/%0d want=%0d/%0d", i, fetch_count, bubble_count, m_fc, m_bc); end total++;
`endif
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    step(1'b0, 2'b10, 32'd0);
    step(1'b1, 2'b10, 32'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 2'b10, 32'd0);
    step(1'b1, 2'b01, 32'h4000_0400);
    step(1'b1, 2'b00, 32'd0);
    step(1'b1, 2'b00, 32'd0);
    if (fetch_count !== 32'd10 || bubble_count !== 32'd3) begin bad++; $display("FAIL perf got=%0d/%0d want=10/3", fetch_count, bubble_count); end total++;
  endtask
`endif

  initial begin
    rst = 1'b0; pc_sel = 2'b00; alu_out = 32'd0; icache_dout = 32'd0;
    test_reset();
    test_sequential();
    test_redirect();
    test_hold();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I pipeline. Owns the program counter and drives the synchronous-read instruction cache. Applies the two-bit next-PC select from the PC-select logic. Registers the fetched instruction into `prev_inst`, which feeds both decode and PC-select; wrong-path and refetched instructions are squashed to NOPs.

## Interface
Parameters:
- `RESET_PC`, 32'h4000_0000: first fetch address after reset.
- `NOP`, 32'h0000_0013: squash value (`addi x0,x0,0`).

Ports:
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `pc_sel` input 2: next-PC select; 00 = hold/refetch, 01 = redirect to `alu_out`, 10 = PC+4, 11 = treated as 10.
- `alu_out` input 32: redirect target from execute.
- `icache_dout` input 32: instruction data for the address issued the previous cycle.
- `icache_addr` output 32: fetch address, combinational from state and `pc_sel`.
- `icache_re` output 1: fetch read enable.
- `pc_out` output 32: address of the instruction currently on `icache_dout`.
- `prev_inst` output 32: registered instruction handed to decode/PC-select.
- `prev_pc` output 32: address of `prev_inst`.
- `inst_valid` output 1: `prev_inst` is a real instruction, not a squash NOP.
- `fetch_misaligned` output 1: one-cycle pulse when a redirect target has bit 1 set.

## Operation
- State machine: RST -> BOOT -> RUN.
  - RST: while `rst`=0.
  - BOOT: exactly one cycle after `rst` rises.
  - RUN: thereafter.
  - `rst`=0 from any state returns to RST at the next edge.
- RST:
  - `icache_re`=0, `icache_addr`=`RESET_PC`.
  - Registers load reset values.
- BOOT:
  - `icache_re`=1, `icache_addr`=`RESET_PC`.
  - `pc_q` <= `RESET_PC`; `prev_inst` <= `NOP`; `inst_valid` <= 0.
  - `icache_dout` is ignored in this cycle.
- RUN, `icache_re`=1, `next_pc` chosen by `pc_sel`:
  - 00: `next_pc` = `pc_q`. `prev_inst` <= `NOP`, `inst_valid` <= 0, because the same instruction is fetched again.
  - 01: `next_pc` = {`alu_out`[31:2], 2'b00}. The instruction on `icache_dout` is wrong-path: `prev_inst` <= `NOP`, `inst_valid` <= 0. `fetch_misaligned` <= `alu_out`[1].
  - 10/11: `next_pc` = `pc_q` + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0). `prev_inst` <= `icache_dout`, `prev_pc` <= `pc_q`, `inst_valid` <= 1.
- In RUN, `icache_addr` = `next_pc` and `pc_q` <= `next_pc` every cycle.
- `pc_out` = `pc_q`.
- `fetch_misaligned` is 0 in all non-redirect cycles.

## Timing
- Reset values:
  - `pc_q` = `RESET_PC`, `prev_pc` = 0, `prev_inst` = `NOP`.
  - `inst_valid` = 0, `fetch_misaligned` = 0, `icache_re` = 0.
- Icache latency is one cycle: an address issued at edge N appears on `icache_dout` during cycle N+1. `pc_out` tracks it.
- First valid `prev_inst` (from `RESET_PC`): two edges after `rst` rises, i.e. BOOT then the first RUN edge with `pc_sel`=10.
- Redirect costs exactly one bubble. With `pc_sel`=01 at edge N, the target is fetched at N, and its instruction enters `prev_inst` at N+1 if `pc_sel`=10.
- Hold keeps the address constant for as many cycles as `pc_sel`=00. One bubble is inserted per hold cycle; no instruction is lost or duplicated.
- `pc_sel` is sampled only in RUN; it is ignored in RST and BOOT.
- If `rst` falls mid-redirect or mid-hold, reset wins at that edge and the pending target is discarded.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `fetch_count` (32) and `bubble_count` (32).
  - `fetch_count` increments on each RUN edge with `inst_valid` next value 1.
  - `bubble_count` increments on each RUN edge with `inst_valid` next value 0.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Reset release, `pc_sel`=10, sequential memory: `icache_addr` = 0x4000_0000, then 0x4000_0004, then 0x4000_0008. The first valid `prev_pc` is 0x4000_0000, on the second edge after release.
- Redirect, `pc_sel`=01 with `alu_out`=0x4000_0100 while `pc_out`=0x4000_0008: `prev_inst`=0x0000_0013 with `inst_valid`=0 for one cycle, then `prev_pc`=0x4000_0100.
- Three cycles of `pc_sel`=00 at `pc_out`=0x4000_0010: `icache_addr` stays 0x4000_0010 and three NOP bubbles are produced. The next valid `prev_pc` is 0x4000_0010, exactly once.
- Redirect with `alu_out`=0x4000_0206: `icache_addr`=0x4000_0204 and `fetch_misaligned`=1 for one cycle. With `alu_out`=0x4000_0205: target 0x4000_0204, `fetch_misaligned`=0.
- `pc_q`=0xFFFF_FFFC with `pc_sel`=10: `icache_addr`=0x0000_0000. Asserting `rst`=0 during a redirect gives `prev_inst`=NOP and `pc_out`=0x4000_0000 next cycle.
- With `FETCH_PERF_EN`: 10 sequential fetches plus 1 redirect plus 2 holds from reset give `fetch_count`=10 and `bubble_count`=3.
